// File: rtl/gps_ack_sched_if.sv
// Result-record channel from gps_ack_sched to the host / tracking-channel allocator.
// GPS_ACK_SCHED_RATIO_EN adds the second-best magnitude field res_second.
interface gps_ack_sched_if;
  logic        res_valid;
  logic        res_ready;
  logic [5:0]  res_sat;
  logic [9:0]  res_code_phase;
  logic [15:0] res_doppler;
  logic [15:0] res_peak;
  logic        res_detected;
  logic        res_timeout;
`ifdef GPS_ACK_SCHED_RATIO_EN
  logic [15:0] res_second;
`endif

  modport master (
`ifdef GPS_ACK_SCHED_RATIO_EN
    output res_second,
`endif
    output res_valid, res_sat, res_code_phase, res_doppler, res_peak, res_detected, res_timeout,
    input  res_ready
  );

  modport slave (
`ifdef GPS_ACK_SCHED_RATIO_EN
    input  res_second,
`endif
    input  res_valid, res_sat, res_code_phase, res_doppler, res_peak, res_detected, res_timeout,
    output res_ready
  );
endinterface

// File: rtl/gps_ack_sched.sv
// PRN scan sequencer for the acquisition engine: one search per enabled PRN, peak tracking,
// threshold detection and one result record per PRN. GPS_ACK_SCHED_RATIO_EN adds peak/second test.
module gps_ack_sched #(
  parameter int unsigned NUM_SAT     = 32,
  parameter int unsigned TIMEOUT_CYC = 4194304,
  parameter int unsigned TMR_W       = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               abort,
  input  logic [NUM_SAT-1:0] sat_mask,
  input  logic [15:0]        threshold,
  output logic               eng_ack_start,
  output logic [5:0]         eng_sat,
  input  logic               eng_corr_complete,
  input  logic [9:0]         eng_code_phase,
  input  logic [15:0]        eng_doppler,
  input  logic [15:0]        eng_integrator,
  input  logic               eng_search_complete,
  gps_ack_sched_if.master    res,
  output logic               busy,
  output logic               done,
  output logic [5:0]         sats_found
);

  localparam logic [TMR_W-1:0] TmrLast   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [5:0]       NumSatIdx = 6'(NUM_SAT);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StStart,
    StWait,
    StReport,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SAT-1:0] mask_q, mask_d;
  logic [15:0]        thr_q, thr_d;
  logic [5:0]         prn_idx_q, prn_idx_d;
  logic [5:0]         eng_sat_q, eng_sat_d;
  logic [15:0]        peak_q, peak_d;
  logic [9:0]         pk_phase_q, pk_phase_d;
  logic [15:0]        pk_dopp_q, pk_dopp_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [5:0]         sats_found_q, sats_found_d;

  logic [5:0]         res_sat_q, res_sat_d;
  logic [9:0]         res_phase_q, res_phase_d;
  logic [15:0]        res_dopp_q, res_dopp_d;
  logic [15:0]        res_peak_q, res_peak_d;
  logic               res_det_q, res_det_d;
  logic               res_to_q, res_to_d;

  // Sample-inclusive peak candidates, so a corr_complete coinciding with
  // search_complete is folded into the reported record.
  logic               new_peak;
  logic [15:0]        nxt_peak;
  logic [9:0]         nxt_phase;
  logic [15:0]        nxt_dopp;
  logic               ratio_ok;
  logic               sel_bit;
  logic               hung;
  logic               det_now;
  logic [NUM_SAT-1:0] mask_shift;

`ifdef GPS_ACK_SCHED_RATIO_EN
  logic [15:0]        second_q, second_d;
  logic [15:0]        nxt_second;
  logic [15:0]        res_second_q, res_second_d;
`endif

  always_comb begin
    new_peak  = eng_corr_complete && (eng_integrator > peak_q);
    nxt_peak  = new_peak ? eng_integrator : peak_q;
    nxt_phase = new_peak ? eng_code_phase : pk_phase_q;
    nxt_dopp  = new_peak ? eng_doppler    : pk_dopp_q;
`ifdef GPS_ACK_SCHED_RATIO_EN
    if (new_peak) begin
      nxt_second = peak_q;
    end else if (eng_corr_complete && (eng_integrator > second_q)) begin
      nxt_second = eng_integrator;
    end else begin
      nxt_second = second_q;
    end
    ratio_ok = {1'b0, nxt_peak} >= {nxt_second, 1'b0};
`else
    ratio_ok = 1'b1;
`endif
  end

  // Out-of-range indices shift to zero, so the last-PRN check never reads past the mask.
  assign mask_shift = mask_q >> prn_idx_q;
  assign sel_bit    = mask_shift[0];

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    thr_d        = thr_q;
    prn_idx_d    = prn_idx_q;
    eng_sat_d    = eng_sat_q;
    peak_d       = peak_q;
    pk_phase_d   = pk_phase_q;
    pk_dopp_d    = pk_dopp_q;
    timer_d      = timer_q;
    sats_found_d = sats_found_q;
    res_sat_d    = res_sat_q;
    res_phase_d  = res_phase_q;
    res_dopp_d   = res_dopp_q;
    res_peak_d   = res_peak_q;
    res_det_d    = res_det_q;
    res_to_d     = res_to_q;
    hung         = 1'b0;
    det_now      = 1'b0;
`ifdef GPS_ACK_SCHED_RATIO_EN
    second_d     = second_q;
    res_second_d = res_second_q;
`endif

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) begin
            mask_d       = sat_mask;
            thr_d        = threshold;
            sats_found_d = '0;
            prn_idx_d    = '0;
            state_d      = StSelect;
          end
        end
        StSelect: begin
          if (prn_idx_q >= NumSatIdx) begin
            state_d = StDone;
          end else if (sel_bit) begin
            eng_sat_d = prn_idx_q + 6'd1;
            state_d   = StStart;
          end else begin
            prn_idx_d = prn_idx_q + 6'd1;
            if (prn_idx_q == NumSatIdx - 6'd1) begin
              state_d = StDone;
            end
          end
        end
        StStart: begin
          peak_d     = '0;
          pk_phase_d = '0;
          pk_dopp_d  = '0;
          timer_d    = '0;
`ifdef GPS_ACK_SCHED_RATIO_EN
          second_d   = '0;
`endif
          state_d    = StWait;
        end
        StWait: begin
          timer_d    = timer_q + TMR_W'(1);
          peak_d     = nxt_peak;
          pk_phase_d = nxt_phase;
          pk_dopp_d  = nxt_dopp;
`ifdef GPS_ACK_SCHED_RATIO_EN
          second_d   = nxt_second;
`endif
          if (eng_search_complete || (timer_q == TmrLast)) begin
            hung        = !eng_search_complete;
            det_now     = !hung && (nxt_peak >= thr_q) && ratio_ok;
            res_sat_d   = eng_sat_q;
            res_phase_d = nxt_phase;
            res_dopp_d  = nxt_dopp;
            res_peak_d  = nxt_peak;
            res_det_d   = det_now;
            res_to_d    = hung;
`ifdef GPS_ACK_SCHED_RATIO_EN
            res_second_d = nxt_second;
`endif
            if (det_now) begin
              sats_found_d = sats_found_q + 6'd1;
            end
            state_d = StReport;
          end
        end
        StReport: begin
          if (res.res_ready) begin
            prn_idx_d = prn_idx_q + 6'd1;
            state_d   = StSelect;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      thr_q        <= '0;
      prn_idx_q    <= '0;
      eng_sat_q    <= '0;
      peak_q       <= '0;
      pk_phase_q   <= '0;
      pk_dopp_q    <= '0;
      timer_q      <= '0;
      sats_found_q <= '0;
      res_sat_q    <= '0;
      res_phase_q  <= '0;
      res_dopp_q   <= '0;
      res_peak_q   <= '0;
      res_det_q    <= 1'b0;
      res_to_q     <= 1'b0;
`ifdef GPS_ACK_SCHED_RATIO_EN
      second_q     <= '0;
      res_second_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      thr_q        <= thr_d;
      prn_idx_q    <= prn_idx_d;
      eng_sat_q    <= eng_sat_d;
      peak_q       <= peak_d;
      pk_phase_q   <= pk_phase_d;
      pk_dopp_q    <= pk_dopp_d;
      timer_q      <= timer_d;
      sats_found_q <= sats_found_d;
      res_sat_q    <= res_sat_d;
      res_phase_q  <= res_phase_d;
      res_dopp_q   <= res_dopp_d;
      res_peak_q   <= res_peak_d;
      res_det_q    <= res_det_d;
      res_to_q     <= res_to_d;
`ifdef GPS_ACK_SCHED_RATIO_EN
      second_q     <= second_d;
      res_second_q <= res_second_d;
`endif
    end
  end

  assign eng_ack_start      = (state_q == StStart);
  assign eng_sat            = eng_sat_q;
  assign busy               = (state_q != StIdle) && (state_q != StDone);
  assign done               = (state_q == StDone);
  assign sats_found         = sats_found_q;
  assign res.res_valid      = (state_q == StReport);
  assign res.res_sat        = res_sat_q;
  assign res.res_code_phase = res_phase_q;
  assign res.res_doppler    = res_dopp_q;
  assign res.res_peak       = res_peak_q;
  assign res.res_detected   = res_det_q;
  assign res.res_timeout    = res_to_q;
`ifdef GPS_ACK_SCHED_RATIO_EN
  assign res.res_second     = res_second_q;
`endif

endmodule
